bullet_overlay_multi: RTL and testbench

//  Multi-channel enemy-shell overlay stage for the 1024x768 VGA pipeline; replaces the single-shell stage.
//  N_BULLETS independent channels, each drawing one shell in direction-dependent geometry.
//  Per-channel hit explosion; sits between background/tank stages and the mouse stage.
//  One-cycle registered stage: timing, rgb and mouse position are delayed together.

---
 rtl/bullet_overlay_pkg.sv | 31 +++
 rtl/bullet_channel.sv | 168 ++++++++++++++++
 rtl/bullet_overlay_multi.sv | 139 +++++++++++++
 tb/tb_bullet_overlay_multi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_overlay_pkg.sv
// Shared types and helpers for the multi-channel shell overlay.
// Holds the channel state encoding, direction codes, default colours and a
// saturating subtract used for the lower edge of every drawing box.
package bullet_overlay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLY     = 2'd1,
      ST_EXPLODE = 2'd2
   } chan_state_t;

   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_RIGHT = 3'd3;
   localparam logic [2:0] DIR_LEFT  = 3'd4;

   localparam logic [11:0] DEF_SHELL_RGB = 12'h000;
   localparam logic [11:0] DEF_EXPL_RGB  = 12'hF80;

   // Codes 5-7 behave exactly like "no shell".
   function automatic logic dir_valid(input logic [2:0] d);
      return (d != DIR_NONE) && (d <= DIR_LEFT);
   endfunction

   // Lower box edges clamp at 0 so a shell near the left/top edge never wraps.
   function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
      return (a > b) ? (a - b) : 12'd0;
   endfunction

endpackage

// File: rtl/bullet_channel.sv
// One shell channel: IDLE/FLY/EXPLODE state machine, explosion position latch,
// frame counter and the pixel-in-box test for the current raster position.
// The explosion part is built only when BULLET_EXPLOSION_EN is defined;
// without it a hit while flying returns the channel straight to IDLE.
module bullet_channel
   import bullet_overlay_pkg::*;
#(
   parameter int          HALF_W      = 2,
   parameter int          HALF_L      = 5,
   parameter int          OFS         = 24,
   parameter logic [11:0] SHELL_RGB   = DEF_SHELL_RGB,
   parameter int          EXPL_HALF   = 6,
   parameter logic [11:0] EXPL_RGB    = DEF_EXPL_RGB,
   parameter int          EXPL_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic [9:0]  xpos,
   input  logic [9:0]  ypos,
   input  logic [2:0]  direction,
   input  logic        hit,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic        draw,
   output logic [11:0] colour,
   output logic        busy
);

   localparam logic [11:0] HW = 12'(HALF_W);
   localparam logic [11:0] HL = 12'(HALF_L);
   localparam logic [11:0] OF = 12'(OFS);

   chan_state_t state_q, state_d;
   logic [11:0] xc, yc, px, py;
   logic [11:0] x_lo, x_hi, y_lo, y_hi;
   logic        box_en;

   assign xc = {2'b00, xpos};
   assign yc = {2'b00, ypos};
   assign px = {1'b0, hcount};
   assign py = {2'b00, vcount};

`ifdef BULLET_EXPLOSION_EN
   localparam logic [11:0] EH = 12'(EXPL_HALF);

   logic [11:0] x_lat_q, x_lat_d, y_lat_q, y_lat_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        enter_explode, last_frame;

   assign enter_explode = (state_q == ST_FLY) && hit;
   assign last_frame    = frame_start && (frame_cnt_q == 8'(EXPL_FRAMES - 1));

   // Capture the impact point and restart frame counting on entry to EXPLODE.
   always_comb begin
      x_lat_d     = x_lat_q;
      y_lat_d     = y_lat_q;
      frame_cnt_d = frame_cnt_q;
      if (enter_explode) begin
         x_lat_d     = xc;
         y_lat_d     = yc;
         frame_cnt_d = 8'd0;
      end else if ((state_q == ST_EXPLODE) && frame_start) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   // Explosion position and frame counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_lat_q     <= '0;
         y_lat_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         x_lat_q     <= x_lat_d;
         y_lat_q     <= y_lat_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
`else
   logic unused_expl;
   assign unused_expl = frame_start ^ (EXPL_HALF != 0) ^ (EXPL_FRAMES != 0) ^ (^EXPL_RGB);
`endif

   // Next-state logic: a hit outranks a simultaneous direction of 0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (dir_valid(direction)) state_d = ST_FLY;
         end
         ST_FLY: begin
            if (hit) begin
`ifdef BULLET_EXPLOSION_EN
               state_d = ST_EXPLODE;
`else
               state_d = ST_IDLE;
`endif
            end else if (!dir_valid(direction)) begin
               state_d = ST_IDLE;
            end
         end
         ST_EXPLODE: begin
`ifdef BULLET_EXPLOSION_EN
            if (last_frame) state_d = ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Box bounds for the current state and heading; flying shells use live position.
   always_comb begin
      box_en = 1'b0;
      colour = SHELL_RGB;
      x_lo   = '0;
      x_hi   = '0;
      y_lo   = '0;
      y_hi   = '0;
      case (state_q)
         ST_FLY: begin
            box_en = 1'b1;
            case (direction)
               DIR_UP: begin
                  x_lo = sat_sub(xc, HW);      x_hi = xc + HW;
                  y_lo = sat_sub(yc, HL);      y_hi = yc + HL;
               end
               DIR_DOWN: begin
                  x_lo = sat_sub(xc, HW);      x_hi = xc + HW;
                  y_lo = sat_sub(yc + OF, HL); y_hi = yc + OF + HL;
               end
               DIR_RIGHT: begin
                  x_lo = sat_sub(xc + OF, HL); x_hi = xc + OF + HL;
                  y_lo = sat_sub(yc, HW);      y_hi = yc + HW;
               end
               DIR_LEFT: begin
                  x_lo = sat_sub(xc, HL);      x_hi = xc + HL;
                  y_lo = sat_sub(yc, HW);      y_hi = yc + HW;
               end
               default: box_en = 1'b0;
            endcase
         end
`ifdef BULLET_EXPLOSION_EN
         ST_EXPLODE: begin
            box_en = 1'b1;
            colour = EXPL_RGB;
            x_lo   = sat_sub(x_lat_q, EH);
            x_hi   = x_lat_q + EH;
            y_lo   = sat_sub(y_lat_q, EH);
            y_hi   = y_lat_q + EH;
         end
`endif
         default: box_en = 1'b0;
      endcase
   end

   assign draw = box_en && (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
   assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/bullet_overlay_multi.sv
// Multi-channel enemy-shell overlay stage for the 1024x768 pipeline.
// N_BULLETS shell channels feed a lowest-index-wins colour mux; every
// timing, counter, colour and mouse signal is delayed by one register.
// Optional explosion support: define BULLET_EXPLOSION_EN.
module bullet_overlay_multi
   import bullet_overlay_pkg::*;
#(
   parameter int          N_BULLETS   = 4,
   parameter int          HALF_W      = 2,
   parameter int          HALF_L      = 5,
   parameter int          OFS         = 24,
   parameter logic [11:0] SHELL_RGB   = DEF_SHELL_RGB,
   parameter int          EXPL_HALF   = 6,
   parameter logic [11:0] EXPL_RGB    = DEF_EXPL_RGB,
   parameter int          EXPL_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [10*N_BULLETS-1:0]  xpos_bullet,
   input  logic [10*N_BULLETS-1:0]  ypos_bullet,
   input  logic [3*N_BULLETS-1:0]   direction,
   input  logic [N_BULLETS-1:0]     hit,
   input  logic                     hblnk,
   input  logic                     vblnk,
   input  logic                     hsync,
   input  logic                     vsync,
   input  logic [10:0]              hcount,
   input  logic [9:0]               vcount,
   input  logic [11:0]              rgb,
   input  logic [11:0]              xpos_m,
   input  logic [11:0]              ypos_m,
   output logic                     hblnk_out,
   output logic                     vblnk_out,
   output logic                     hsync_out,
   output logic                     vsync_out,
   output logic [10:0]              hcount_out,
   output logic [9:0]               vcount_out,
   output logic [11:0]              rgb_out,
   output logic [11:0]              xpos_m_out,
   output logic [11:0]              ypos_m_out,
   output logic [N_BULLETS-1:0]     busy
);

   logic [N_BULLETS-1:0] ch_draw;
   logic [N_BULLETS-1:0] ch_busy;
   logic [11:0]          ch_colour [N_BULLETS];
   logic                 frame_start;

   logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic [10:0] hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic [11:0] rgb_q, rgb_d, xpos_m_q, xpos_m_d, ypos_m_q, ypos_m_d;

   // The delayed vblnk doubles as the previous-cycle value for edge detection.
   assign frame_start = vblnk && !vblnk_q;

   generate
      for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_chan
         bullet_channel #(
            .HALF_W      (HALF_W),
            .HALF_L      (HALF_L),
            .OFS         (OFS),
            .SHELL_RGB   (SHELL_RGB),
            .EXPL_HALF   (EXPL_HALF),
            .EXPL_RGB    (EXPL_RGB),
            .EXPL_FRAMES (EXPL_FRAMES)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .frame_start (frame_start),
            .xpos        (xpos_bullet[10*gi +: 10]),
            .ypos        (ypos_bullet[10*gi +: 10]),
            .direction   (direction[3*gi +: 3]),
            .hit         (hit[gi]),
            .hcount      (hcount),
            .vcount      (vcount),
            .draw        (ch_draw[gi]),
            .colour      (ch_colour[gi]),
            .busy        (ch_busy[gi])
         );
      end
   endgenerate

   // Next values: pass-through signals plus the priority-composed colour.
   always_comb begin
      hblnk_d  = hblnk;
      vblnk_d  = vblnk;
      hsync_d  = hsync;
      vsync_d  = vsync;
      hcount_d = hcount;
      vcount_d = vcount;
      xpos_m_d = xpos_m;
      ypos_m_d = ypos_m;
      rgb_d    = rgb;
      if (!(hblnk || vblnk)) begin
         // Scan from the top index down so the lowest drawing channel lands last.
         for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (ch_draw[i]) rgb_d = ch_colour[i];
         end
      end
   end

   // Output stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hblnk_q  <= 1'b0;
         vblnk_q  <= 1'b0;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         rgb_q    <= '0;
         xpos_m_q <= '0;
         ypos_m_q <= '0;
      end else begin
         hblnk_q  <= hblnk_d;
         vblnk_q  <= vblnk_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         rgb_q    <= rgb_d;
         xpos_m_q <= xpos_m_d;
         ypos_m_q <= ypos_m_d;
      end
   end

   assign hblnk_out  = hblnk_q;
   assign vblnk_out  = vblnk_q;
   assign hsync_out  = hsync_q;
   assign vsync_out  = vsync_q;
   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign rgb_out    = rgb_q;
   assign xpos_m_out = xpos_m_q;
   assign ypos_m_out = ypos_m_q;
   assign busy       = ch_busy;

endmodule

// File: tb/tb_bullet_overlay_multi.sv
// Self-checking bench for bullet_overlay_multi: directed scenarios followed by
// randomized traffic, all compared against a behavioural per-channel model.
module tb_bullet_overlay_multi;

   localparam int N   = 4;
   localparam int HW  = 2;
   localparam int HL  = 5;
   localparam int OFS = 24;
   localparam int EH  = 6;
   localparam int EF  = 8;
   localparam logic [11:0] SHELL = 12'h000;
   localparam logic [11:0] EXPL  = 12'hF80;
`ifdef BULLET_EXPLOSION_EN
   localparam bit EXPL_EN = 1'b1;
`else
   localparam bit EXPL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [9:0]  bx [N];
   logic [9:0]  by [N];
   logic [2:0]  bdir [N];
   logic [N-1:0] bhit;
   logic [10*N-1:0] xpos_bullet, ypos_bullet;
   logic [3*N-1:0]  direction;
   logic        hblnk, vblnk, hsync, vsync;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [11:0] rgb, xpos_m, ypos_m;
   logic        hblnk_out, vblnk_out, hsync_out, vsync_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic [11:0] rgb_out, xpos_m_out, ypos_m_out;
   logic [N-1:0] busy;

   always_comb begin
      xpos_bullet = '0;
      ypos_bullet = '0;
      direction   = '0;
      for (int i = 0; i < N; i++) begin
         xpos_bullet[10*i +: 10] = bx[i];
         ypos_bullet[10*i +: 10] = by[i];
         direction[3*i +: 3]     = bdir[i];
      end
   end

   bullet_overlay_multi dut (
      .clk(clk), .rst(rst),
      .xpos_bullet(xpos_bullet), .ypos_bullet(ypos_bullet),
      .direction(direction), .hit(bhit),
      .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
      .hcount(hcount), .vcount(vcount), .rgb(rgb),
      .xpos_m(xpos_m), .ypos_m(ypos_m),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .rgb_out(rgb_out), .xpos_m_out(xpos_m_out), .ypos_m_out(ypos_m_out),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 flying, 2 exploding.
   int m_mode [N];
   int m_ex [N];
   int m_ey [N];
   int m_left [N];
   bit m_prev_vb;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mode[i] = 0; m_ex[i] = 0; m_ey[i] = 0; m_left[i] = 0;
      end
      m_prev_vb = 1'b0;
   endtask

   function automatic bit dir_ok(input logic [2:0] d);
      return (d >= 3'd1) && (d <= 3'd4);
   endfunction

   // Shell/explosion rectangle test in plain signed arithmetic; a negative
   // lower edge behaves like a clamp at 0 for non-negative pixels.
   function automatic bit covers(input int i, input int px, input int py);
      int x, y, xl, xh, yl, yh;
      x = int'(bx[i]);
      y = int'(by[i]);
      if (m_mode[i] == 2) begin
         xl = m_ex[i] - EH; xh = m_ex[i] + EH;
         yl = m_ey[i] - EH; yh = m_ey[i] + EH;
      end else if (m_mode[i] == 1) begin
         case (bdir[i])
            3'd1: begin xl = x - HW; xh = x + HW; yl = y - HL; yh = y + HL; end
            3'd2: begin xl = x - HW; xh = x + HW; yl = y + OFS - HL; yh = y + OFS + HL; end
            3'd3: begin xl = x + OFS - HL; xh = x + OFS + HL; yl = y - HW; yh = y + HW; end
            3'd4: begin xl = x - HL; xh = x + HL; yl = y - HW; yh = y + HW; end
            default: return 1'b0;
         endcase
      end else begin
         return 1'b0;
      end
      return (px >= xl) && (px <= xh) && (py >= yl) && (py <= yh);
   endfunction

   // One clock: predict outputs from current inputs and model, advance model, compare.
   task automatic cycle(input string tag);
      logic [11:0]  er;
      logic [48:0]  ep;
      logic [N-1:0] eb;
      bit fs;
      er = rgb;
      if (!(hblnk || vblnk)) begin
         for (int i = N - 1; i >= 0; i--)
            if (covers(i, int'(hcount), int'(vcount))) er = (m_mode[i] == 2) ? EXPL : SHELL;
      end
      ep = {hblnk, vblnk, hsync, vsync, hcount, vcount, xpos_m, ypos_m};
      fs = vblnk && !m_prev_vb;
      m_prev_vb = vblnk;
      for (int i = 0; i < N; i++) begin
         case (m_mode[i])
            0: if (dir_ok(bdir[i])) m_mode[i] = 1;
            1: begin
               if (bhit[i]) begin
                  if (EXPL_EN) begin
                     m_mode[i] = 2; m_ex[i] = int'(bx[i]); m_ey[i] = int'(by[i]); m_left[i] = EF;
                  end else begin
                     m_mode[i] = 0;
                  end
               end else if (!dir_ok(bdir[i])) begin
                  m_mode[i] = 0;
               end
            end
            default: begin
               if (fs) begin
                  m_left[i]--;
                  if (m_left[i] == 0) m_mode[i] = 0;
               end
            end
         endcase
         eb[i] = (m_mode[i] != 0);
      end
      @(posedge clk);
      #1;
      check({tag, ".rgb"}, 64'(rgb_out), 64'(er));
      check({tag, ".busy"}, 64'(busy), 64'(eb));
      check({tag, ".pass"}, 64'({hblnk_out, vblnk_out, hsync_out, vsync_out, hcount_out,
                                 vcount_out, xpos_m_out, ypos_m_out}), 64'(ep));
      n_txn++;
      $display("txn %0d %s h=%0d v=%0d rgb_out=%h busy=%b", n_txn, tag, hcount_out, vcount_out, rgb_out, busy);
   endtask

   task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
      hcount = 11'(h);
      vcount = 10'(v);
      cycle(tag);
      check({tag, ".const"}, 64'(rgb_out), 64'(exp));
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         bx[i] = '0; by[i] = '0; bdir[i] = '0;
      end
      bhit = '0;
      hblnk = 0; vblnk = 0; hsync = 0; vsync = 0;
      hcount = '0; vcount = '0; rgb = '0; xpos_m = '0; ypos_m = '0;
   endtask

   initial begin
      int h, v, j, cx, cy;
      clear_inputs();
      model_reset();
      #1 rst = 1'b1;
      #2;
      check("reset.outs", 64'({rgb_out, busy, hblnk_out, vblnk_out, hsync_out, vsync_out,
                               hcount_out, vcount_out, xpos_m_out, ypos_m_out}), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Single upward shell at (100,200), background 5A5.
      bdir[0] = 3'd1; bx[0] = 10'd100; by[0] = 10'd200; rgb = 12'h5A5;
      cycle("t2.arm");
      probe("t2.tl", 98, 195, 12'h000);
      probe("t2.br", 102, 205, 12'h000);
      probe("t2.l", 97, 200, 12'h5A5);
      probe("t2.r", 103, 200, 12'h5A5);
      probe("t2.t", 100, 194, 12'h5A5);
      probe("t2.b", 100, 206, 12'h5A5);

      // Downward shell on ch1: box rows 319..329.
      bdir[1] = 3'd2; bx[1] = 10'd300; by[1] = 10'd300;
      cycle("t3.arm");
      probe("t3.top", 300, 319, 12'h000);
      probe("t3.above", 300, 318, 12'h5A5);
      probe("t3.bot", 300, 329, 12'h000);
      probe("t3.below", 300, 330, 12'h5A5);
      bx[0] = 10'd300; by[0] = 10'd324;
      probe("t3.overlap", 300, 324, 12'h000);

      // Hit ch0; explosion stays at the latched point while input moves.
      bdir[0] = 3'd0; bhit[0] = 1'b1;
      cycle("t4.hit");
      bhit[0] = 1'b0;
      check("t4.busy", 64'(busy[0]), 64'(EXPL_EN));
      bx[0] = 10'd500;
      probe("t4.prio", 300, 320, EXPL_EN ? EXPL : SHELL);
      probe("t4.edge", 306, 330, EXPL_EN ? EXPL : 12'h5A5);
      probe("t4.out", 307, 324, 12'h5A5);
      for (int k = 1; k <= EF; k++) begin
         vblnk = 1'b1; cycle("t4.vb1");
         vblnk = 1'b0; cycle("t4.vb0");
         if (k == EF - 1) check("t4.busy7", 64'(busy[0]), 64'(EXPL_EN));
      end
      check("t4.done", 64'(busy[0]), 64'(0));

      // Direction 0 and hit in the same cycle.
      bdir[0] = 3'd1; bx[0] = 10'd200; by[0] = 10'd100;
      cycle("t5.arm");
      bdir[0] = 3'd0; bhit[0] = 1'b1;
      cycle("t5.hit");
      bhit[0] = 1'b0;
      check("t5.busy", 64'(busy[0]), 64'(EXPL_EN));
      probe("t5.draw", 200, 100, EXPL_EN ? EXPL : 12'h5A5);

      // Mid-frame reset with ch0 active.
      bdir[0] = 3'd1; xpos_m = 12'hFFF; ypos_m = 12'h123; hsync = 1'b1;
      cycle("t1.pre");
      rst = 1'b1;
      #1;
      check("t1.rst_now", 64'({rgb_out, busy, hblnk_out, vblnk_out, hsync_out, vsync_out,
                               hcount_out, vcount_out, xpos_m_out, ypos_m_out}), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check("t1.busy", 64'(busy), 64'(0));

      // Left shell at x=1: box starts at column 0 with no wrap.
      clear_inputs();
      bdir[0] = 3'd4; bx[0] = 10'd1; by[0] = 10'd50; rgb = 12'hABC;
      cycle("t6.arm");
      probe("t6.h0", 0, 50, 12'h000);
      probe("t6.h6", 6, 50, 12'h000);
      probe("t6.h7", 7, 50, 12'hABC);
      probe("t6.hmax", 2047, 50, 12'hABC);

      // Randomized traffic around the shells.
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) bdir[i] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) begin
               bx[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
               by[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
            end
            bhit[i] = ($urandom_range(0, 39) == 0);
         end
         if ($urandom_range(0, 5) == 0) vblnk = ~vblnk;
         hblnk = ($urandom_range(0, 7) == 0);
         hsync = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
         j = int'($urandom_range(0, N - 1));
         cx = (m_mode[j] == 2) ? m_ex[j] : int'(bx[j]);
         cy = (m_mode[j] == 2) ? m_ey[j] : int'(by[j]);
         h = cx + int'($urandom_range(0, 50)) - 12;
         v = cy + int'($urandom_range(0, 50)) - 12;
         if (h < 0) h = 0;
         if (v < 0) v = 0;
         hcount = 11'(h);
         vcount = 10'(v);
         rgb    = 12'($urandom);
         xpos_m = 12'($urandom);
         ypos_m = 12'($urandom);
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
